// File: rtl/fpu_req_dispatch.sv
// fpu_req_dispatch: issue-side FPU front end.
// Allocates completion tags, registers requests toward the FPU, and matches
// out-of-order FPU responses back to issuer metadata stored per tag.
// Optional build macro: FPU_DISPATCH_STATS_EN enables the tag-stall counter.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST_FPU_BITS
`define INST_FPU_BITS 4
`endif
`ifndef INST_FMT_BITS
`define INST_FMT_BITS 2
`endif
`ifndef INST_FRM_BITS
`define INST_FRM_BITS 3
`endif

module fpu_req_dispatch #(
   parameter int NUM_LANES  = 1,
   parameter int NUM_TAGS   = 4,
   parameter int META_WIDTH = 8,
   localparam int TAG_WIDTH = $clog2(NUM_TAGS),
   localparam int DW        = NUM_LANES * `XLEN
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      in_valid,
   input  logic [`INST_FPU_BITS-1:0] in_op_type,
   input  logic [`INST_FMT_BITS-1:0] in_fmt,
   input  logic [`INST_FRM_BITS-1:0] in_frm,
   input  logic [DW-1:0]             in_dataa,
   input  logic [DW-1:0]             in_datab,
   input  logic [DW-1:0]             in_datac,
   input  logic [META_WIDTH-1:0]     in_meta,
   output logic                      in_ready,
   output logic                      fpu_req_valid,
   output logic [`INST_FPU_BITS-1:0] fpu_req_op_type,
   output logic [`INST_FMT_BITS-1:0] fpu_req_fmt,
   output logic [`INST_FRM_BITS-1:0] fpu_req_frm,
   output logic [DW-1:0]             fpu_req_dataa,
   output logic [DW-1:0]             fpu_req_datab,
   output logic [DW-1:0]             fpu_req_datac,
   output logic [TAG_WIDTH-1:0]      fpu_req_tag,
   input  logic                      fpu_req_ready,
   input  logic                      fpu_rsp_valid,
   input  logic [TAG_WIDTH-1:0]      fpu_rsp_tag,
   input  logic [DW-1:0]             fpu_rsp_result,
   output logic                      fpu_rsp_ready,
   output logic                      out_valid,
   output logic [DW-1:0]             out_result,
   output logic [META_WIDTH-1:0]     out_meta,
   input  logic                      out_ready,
   output logic                      busy,
   output logic [31:0]               perf_tag_stalls
);

   // Lowest-index free tag; the mask must be non-empty when the result is used.
   function automatic logic [TAG_WIDTH-1:0] lowest_free(input logic [NUM_TAGS-1:0] m);
      lowest_free = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (m[i]) lowest_free = TAG_WIDTH'(i);
      end
   endfunction

   logic [NUM_TAGS-1:0]   free_mask;
   logic [NUM_TAGS-1:0]   free_nxt;
   logic [META_WIDTH-1:0] meta_tbl [NUM_TAGS];
   logic [TAG_WIDTH-1:0]  alloc_tag;
   logic                  req_fire;
   logic                  rsp_fire;

   logic                      req_vld_p1;
   logic [`INST_FPU_BITS-1:0] req_op_p1;
   logic [`INST_FMT_BITS-1:0] req_fmt_p1;
   logic [`INST_FRM_BITS-1:0] req_frm_p1;
   logic [DW-1:0]             req_a_p1;
   logic [DW-1:0]             req_b_p1;
   logic [DW-1:0]             req_c_p1;
   logic [TAG_WIDTH-1:0]      req_tag_p1;

   logic                  out_vld_p1;
   logic [DW-1:0]         out_res_p1;
   logic [META_WIDTH-1:0] out_meta_p1;

   assign alloc_tag     = lowest_free(free_mask);
   assign in_ready      = (|free_mask) & (~req_vld_p1 | fpu_req_ready);
   assign req_fire      = in_valid & in_ready;
   assign fpu_rsp_ready = ~out_vld_p1 | out_ready;
   assign rsp_fire      = fpu_rsp_valid & fpu_rsp_ready;

   // Next free mask: allocation sees the pre-update mask, so a freed tag is reusable next cycle.
   always_comb begin
      free_nxt = free_mask;
      if (req_fire) free_nxt[alloc_tag] = 1'b0;
      if (rsp_fire) free_nxt[fpu_rsp_tag] = 1'b1;
   end

   // Tag free-mask register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) free_mask <= '1;
      else          free_mask <= free_nxt;
   end

   // Metadata table written at allocation; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (req_fire) meta_tbl[alloc_tag] <= in_meta;
   end

   // ---- stage p1: FPU request register ----
   // Request register holds fields stable while the FPU stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_vld_p1 <= 1'b0;
         req_op_p1  <= '0;
         req_fmt_p1 <= '0;
         req_frm_p1 <= '0;
         req_a_p1   <= '0;
         req_b_p1   <= '0;
         req_c_p1   <= '0;
         req_tag_p1 <= '0;
      end else if (req_fire) begin
         req_vld_p1 <= 1'b1;
         req_op_p1  <= in_op_type;
         req_fmt_p1 <= in_fmt;
         req_frm_p1 <= in_frm;
         req_a_p1   <= in_dataa;
         req_b_p1   <= in_datab;
         req_c_p1   <= in_datac;
         req_tag_p1 <= alloc_tag;
      end else if (fpu_req_ready) begin
         req_vld_p1 <= 1'b0;
      end
   end

   // ---- stage p1: writeback register ----
   // Response register pairs the FPU result with the metadata stored under its tag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_vld_p1  <= 1'b0;
         out_res_p1  <= '0;
         out_meta_p1 <= '0;
      end else if (rsp_fire) begin
         out_vld_p1  <= 1'b1;
         out_res_p1  <= fpu_rsp_result;
         out_meta_p1 <= meta_tbl[fpu_rsp_tag];
      end else if (out_ready) begin
         out_vld_p1 <= 1'b0;
      end
   end

   assign fpu_req_valid   = req_vld_p1;
   assign fpu_req_op_type = req_op_p1;
   assign fpu_req_fmt     = req_fmt_p1;
   assign fpu_req_frm     = req_frm_p1;
   assign fpu_req_dataa   = req_a_p1;
   assign fpu_req_datab   = req_b_p1;
   assign fpu_req_datac   = req_c_p1;
   assign fpu_req_tag     = req_tag_p1;
   assign out_valid       = out_vld_p1;
   assign out_result      = out_res_p1;
   assign out_meta        = out_meta_p1;
   assign busy            = (~&free_mask) | req_vld_p1 | out_vld_p1;

`ifdef FPU_DISPATCH_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      sat_inc = (&v) ? v : v + 32'd1;
   endfunction

   logic [31:0] stall_cnt;

   // Count cycles where the issuer waits only because every tag is outstanding.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                     stall_cnt <= '0;
      else if (in_valid & ~|free_mask)  stall_cnt <= sat_inc(stall_cnt);
   end

   assign perf_tag_stalls = stall_cnt;
`else
   assign perf_tag_stalls = 32'd0;
`endif

`ifndef SYNTHESIS
   // A response must name a tag that is currently outstanding.
   rsp_tag_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
      rsp_fire |-> !free_mask[fpu_rsp_tag]);
`endif

endmodule

// File: tb/tb_fpu_req_dispatch.sv
// Self-checking bench for fpu_req_dispatch: directed scenarios with literal
// expectations plus a per-cycle comparison against a tag/metadata model.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST_FPU_BITS
`define INST_FPU_BITS 4
`endif
`ifndef INST_FMT_BITS
`define INST_FMT_BITS 2
`endif
`ifndef INST_FRM_BITS
`define INST_FRM_BITS 3
`endif

module tb_fpu_req_dispatch;
   localparam int NT = 4;
   localparam int DW = `XLEN;

   logic clk = 1'b0;
   logic reset_n;
   logic in_valid;
   logic [`INST_FPU_BITS-1:0] in_op_type, fpu_req_op_type;
   logic [`INST_FMT_BITS-1:0] in_fmt, fpu_req_fmt;
   logic [`INST_FRM_BITS-1:0] in_frm, fpu_req_frm;
   logic [DW-1:0] in_dataa, in_datab, in_datac;
   logic [DW-1:0] fpu_req_dataa, fpu_req_datab, fpu_req_datac;
   logic [7:0] in_meta, out_meta;
   logic in_ready, fpu_req_valid, fpu_req_ready;
   logic [1:0] fpu_req_tag, fpu_rsp_tag;
   logic fpu_rsp_valid, fpu_rsp_ready;
   logic [DW-1:0] fpu_rsp_result, out_result;
   logic out_valid, out_ready, busy;
   logic [31:0] perf_tag_stalls;

   int n_pass = 0;
   int n_total = 0;

   fpu_req_dispatch #(.NUM_LANES(1), .NUM_TAGS(NT), .META_WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
      .in_op_type(in_op_type), .in_fmt(in_fmt), .in_frm(in_frm),
      .in_dataa(in_dataa), .in_datab(in_datab), .in_datac(in_datac),
      .in_meta(in_meta), .in_ready(in_ready),
      .fpu_req_valid(fpu_req_valid), .fpu_req_op_type(fpu_req_op_type),
      .fpu_req_fmt(fpu_req_fmt), .fpu_req_frm(fpu_req_frm),
      .fpu_req_dataa(fpu_req_dataa), .fpu_req_datab(fpu_req_datab),
      .fpu_req_datac(fpu_req_datac), .fpu_req_tag(fpu_req_tag),
      .fpu_req_ready(fpu_req_ready), .fpu_rsp_valid(fpu_rsp_valid),
      .fpu_rsp_tag(fpu_rsp_tag), .fpu_rsp_result(fpu_rsp_result),
      .fpu_rsp_ready(fpu_rsp_ready), .out_valid(out_valid),
      .out_result(out_result), .out_meta(out_meta), .out_ready(out_ready),
      .busy(busy), .perf_tag_stalls(perf_tag_stalls)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: set of outstanding tags, per-tag metadata, one request slot, one writeback slot.
   bit                        m_out_tag [NT];
   logic [7:0]                m_meta [NT];
   bit                        m_rv, m_ov;
   logic [`INST_FPU_BITS-1:0] m_op;
   logic [`INST_FMT_BITS-1:0] m_fmt;
   logic [`INST_FRM_BITS-1:0] m_frm;
   logic [DW-1:0]             m_a, m_b, m_c, m_res;
   logic [1:0]                m_tag;
   logic [7:0]                m_ometa;
   int unsigned               m_stalls;

   function automatic int free_count();
      int n = 0;
      for (int i = 0; i < NT; i++) if (!m_out_tag[i]) n++;
      return n;
   endfunction

   function automatic int first_free();
      for (int i = 0; i < NT; i++) if (!m_out_tag[i]) return i;
      return 0;
   endfunction

   always @(posedge clk or negedge reset_n) begin : model
      int nf, ff;
      bit acc, racc;
      if (!reset_n) begin
         for (int i = 0; i < NT; i++) m_out_tag[i] = 1'b0;
         m_rv = 0; m_ov = 0; m_op = '0; m_fmt = '0; m_frm = '0;
         m_a = '0; m_b = '0; m_c = '0; m_res = '0; m_tag = '0; m_ometa = '0;
         m_stalls = 0;
      end else begin
         nf   = free_count();
         ff   = first_free();
         acc  = in_valid && (nf > 0) && (!m_rv || fpu_req_ready);
         racc = fpu_rsp_valid && (!m_ov || out_ready);
`ifdef FPU_DISPATCH_STATS_EN
         if (in_valid && nf == 0 && m_stalls != 32'hFFFF_FFFF) m_stalls++;
`endif
         if (racc) begin
            m_ov = 1; m_res = fpu_rsp_result; m_ometa = m_meta[fpu_rsp_tag];
            m_out_tag[fpu_rsp_tag] = 1'b0;
         end else if (out_ready) m_ov = 0;
         if (acc) begin
            m_out_tag[ff] = 1'b1; m_meta[ff] = in_meta;
            m_rv = 1; m_op = in_op_type; m_fmt = in_fmt; m_frm = in_frm;
            m_a = in_dataa; m_b = in_datab; m_c = in_datac; m_tag = 2'(ff);
         end else if (fpu_req_ready) m_rv = 0;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("m_in_ready", in_ready, (free_count() > 0) && (!m_rv || fpu_req_ready));
      chk("m_req_valid", fpu_req_valid, m_rv);
      chk("m_rsp_ready", fpu_rsp_ready, !m_ov || out_ready);
      chk("m_out_valid", out_valid, m_ov);
      chk("m_busy", busy, (free_count() < NT) || m_rv || m_ov);
      chk("m_perf", perf_tag_stalls, m_stalls);
      if (m_rv) begin
         chk("m_req_tag", fpu_req_tag, m_tag);
         chk("m_req_fields", {fpu_req_op_type, fpu_req_fmt, fpu_req_frm}, {m_op, m_fmt, m_frm});
         chk("m_req_a", fpu_req_dataa, m_a);
         chk("m_req_b", fpu_req_datab, m_b);
         chk("m_req_c", fpu_req_datac, m_c);
      end
      if (m_ov) begin
         chk("m_out_result", out_result, m_res);
         chk("m_out_meta", out_meta, m_ometa);
      end
   end

   task automatic respond(input logic [1:0] t, input logic [DW-1:0] r);
      fpu_rsp_valid = 1; fpu_rsp_tag = t; fpu_rsp_result = r;
      tick();
      fpu_rsp_valid = 0;
   endtask

   task automatic issue(input logic [7:0] m, input logic [DW-1:0] a);
      in_valid = 1; in_meta = m; in_dataa = a; in_datab = ~a; in_datac = a ^ 32'h5555_5555;
      tick();
      in_valid = 0;
   endtask

   initial begin
      logic [1:0] drain_tag [4];
      logic [7:0] drain_meta [4];
      logic [1:0] ooo_tag [3];
      logic [7:0] ooo_meta [3];
      reset_n = 0; in_valid = 0; in_op_type = 0; in_fmt = 0; in_frm = 0;
      in_dataa = 0; in_datab = 0; in_datac = 0; in_meta = 0;
      fpu_req_ready = 1; fpu_rsp_valid = 0; fpu_rsp_tag = 0; fpu_rsp_result = 0; out_ready = 1;
      repeat (2) tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_req_valid", fpu_req_valid, 0);
      chk("rst_rsp_ready", fpu_rsp_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_perf", perf_tag_stalls, 0);
      chk("rst_req_tag", fpu_req_tag, 0);
      chk("rst_req_dataa", fpu_req_dataa, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_meta", out_meta, 0);
      reset_n = 1;
      tick();

      // Single op
      in_op_type = 4'h3; in_fmt = 2'd1; in_frm = 3'd2;
      issue(8'h5A, 32'h4000_0000);
      chk("s1_req_valid", fpu_req_valid, 1);
      chk("s1_req_tag", fpu_req_tag, 0);
      chk("s1_req_dataa", fpu_req_dataa, 32'h4000_0000);
      chk("s1_req_op", fpu_req_op_type, 4'h3);
      tick();
      chk("s1_req_taken", fpu_req_valid, 0);
      respond(2'd0, 32'h3F80_0000);
      chk("s1_out_valid", out_valid, 1);
      chk("s1_out_meta", out_meta, 8'h5A);
      chk("s1_out_result", out_result, 32'h3F80_0000);
      chk("s1_busy_held", busy, 1);
      tick();
      chk("s1_out_done", out_valid, 0);
      chk("s1_busy_idle", busy, 0);

      // Exhaustion, then stall cycles
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in_meta = 8'h20 + 8'(i); in_dataa = 32'h100 + i;
         tick();
         chk("ex_tag", fpu_req_tag, i);
      end
      chk("ex_in_ready", in_ready, 0);
      repeat (5) tick();
      chk("ex_no_accept", fpu_req_valid, 0);
`ifdef FPU_DISPATCH_STATS_EN
      chk("ex_perf", perf_tag_stalls, 5);
`else
      chk("ex_perf", perf_tag_stalls, 0);
`endif
      in_valid = 0;
      respond(2'd2, 32'hC0DE_0002);
      chk("ex_out_meta", out_meta, 8'h22);
      chk("ex_in_ready_back", in_ready, 1);
      issue(8'h30, 32'h0000_0300);
      chk("ex_realloc_tag", fpu_req_tag, 2);

      // Same-cycle free and request with all tags outstanding
      chk("sc_full", in_ready, 0);
      in_valid = 1; in_meta = 8'h40; in_dataa = 32'h0000_0400;
      respond(2'd1, 32'hC0DE_0001);
      chk("sc_no_accept", fpu_req_valid, 0);
      chk("sc_out_meta", out_meta, 8'h21);
      chk("sc_in_ready", in_ready, 1);
      tick();
      in_valid = 0;
      chk("sc_accept", fpu_req_valid, 1);
      chk("sc_tag", fpu_req_tag, 1);
      drain_tag = '{2'd0, 2'd3, 2'd2, 2'd1};
      drain_meta = '{8'h20, 8'h23, 8'h30, 8'h40};
      for (int i = 0; i < 4; i++) begin
         respond(drain_tag[i], 32'hD000_0000 + i);
         chk("sc_drain_meta", out_meta, drain_meta[i]);
      end
      tick();
      chk("sc_drained", busy, 0);

      // Out-of-order completion
      issue(8'h10, 32'h10);
      issue(8'h11, 32'h11);
      issue(8'h12, 32'h12);
      ooo_tag = '{2'd2, 2'd0, 2'd1};
      ooo_meta = '{8'h12, 8'h10, 8'h11};
      for (int i = 0; i < 3; i++) begin
         respond(ooo_tag[i], 32'hE000_0000 + i);
         chk("ooo_meta", out_meta, ooo_meta[i]);
      end
      tick();

      // Request backpressure
      fpu_req_ready = 0;
      issue(8'h50, 32'hAAAA_0001);
      chk("bp_tag", fpu_req_tag, 0);
      in_valid = 1; in_meta = 8'h55; in_dataa = 32'hBBBB_0002;
      repeat (3) begin
         chk("bp_in_ready", in_ready, 0);
         tick();
         chk("bp_valid", fpu_req_valid, 1);
         chk("bp_dataa", fpu_req_dataa, 32'hAAAA_0001);
         chk("bp_tag_stable", fpu_req_tag, 0);
      end
      fpu_req_ready = 1;
      tick();
      in_valid = 0;
      chk("bp_next_tag", fpu_req_tag, 1);
      chk("bp_next_dataa", fpu_req_dataa, 32'hBBBB_0002);
      tick();

      // Writeback backpressure
      out_ready = 0;
      respond(2'd0, 32'h1111_1111);
      chk("wb_rsp_ready", fpu_rsp_ready, 0);
      chk("wb_meta", out_meta, 8'h50);
      fpu_rsp_valid = 1; fpu_rsp_tag = 2'd1; fpu_rsp_result = 32'h2222_2222;
      repeat (2) tick();
      chk("wb_held_result", out_result, 32'h1111_1111);
      out_ready = 1;
      tick();
      fpu_rsp_valid = 0;
      chk("wb_second_result", out_result, 32'h2222_2222);
      chk("wb_second_meta", out_meta, 8'h55);
      tick();
      chk("wb_idle", busy, 0);

      // Reset mid-flight
      out_ready = 0;
      for (int i = 0; i < 4; i++) issue(8'h60 + 8'(i), 32'h600 + i);
      respond(2'd3, 32'h3333_3333);
      chk("rm_out_valid", out_valid, 1);
      #2 reset_n = 0;
      #1;
      chk("rm_in_ready", in_ready, 1);
      chk("rm_req_valid", fpu_req_valid, 0);
      chk("rm_out_valid0", out_valid, 0);
      chk("rm_busy", busy, 0);
      chk("rm_perf", perf_tag_stalls, 0);
      chk("rm_req_tag", fpu_req_tag, 0);
      chk("rm_out_meta", out_meta, 0);
      tick();
      reset_n = 1; out_ready = 1;
      tick();
      issue(8'h70, 32'h700);
      chk("rm_first_tag", fpu_req_tag, 0);
      tick();
      respond(2'd0, 32'h7777_7777);
      chk("rm_out_meta2", out_meta, 8'h70);
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
